// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit sitting between the execute stage and a
// handshaked data memory. One access at a time: the request is latched in
// IDLE, presented to memory in ACCESS until mem_ready, and completion is
// signalled with a one-cycle done pulse in DONE. Stores get byte-lane strobes
// and lane-replicated write data; loads are lane-selected, sign/zero-extended
// and registered into data_out.
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN):
//   defined   : misaligned half/word accesses skip memory, go straight to DONE
//               and raise misalign for that cycle; data_out is untouched.
//   undefined : misalign is tied low and misaligned accesses are forced
//               aligned (half uses addr[1] only, word ignores addr[1:0]).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_read/mem_write  request from execute stage (read wins if both)
//   funct3              size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   addr, store_data    byte address and store operand
//   stall               combinational pipeline hold
//   done, misalign      one-cycle completion pulse and misalign flag
//   data_out            registered, formatted load result
//   mem_req/we/addr/wdata/wstrb  memory request side (registered)
//   mem_ready, mem_rdata          memory response side
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic                req_s;
  logic                accept_s;
  logic                stall_s;
  logic                misaligned_s;

  logic                mem_req_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [3:0]          mem_wstrb_r;
  logic [2:0]          funct3_r;
  logic [1:0]          lane_r;
  logic                is_load_r;
  logic                done_r;
  logic                misalign_r;
  logic [DATA_W-1:0]   data_out_r;

  // Byte-lane enables for a store; funct3[1:0] of 10/11 is treated as word.
  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] lane);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << lane;
      2'b01:   strb = lane[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate the sub-word operand across every lane so any strobe lines up.
  function automatic logic [DATA_W-1:0] store_wdata(input logic [2:0]        f3,
                                                    input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane select plus sign/zero extension; funct3[2] selects zero extension.
  function automatic logic [DATA_W-1:0] format_load(input logic [2:0]        f3,
                                                    input logic [1:0]        lane,
                                                    input logic [DATA_W-1:0] rd);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = rd[{lane, 3'b000} +: 8];
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {{(DATA_W-8){1'b0}}, b}  : {{(DATA_W-8){b[7]}}, b};
      2'b01:   r = f3[2] ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign req_s = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
  // Detect half/word accesses that do not sit on their natural boundary.
  always_comb begin
    misaligned_s = 1'b0;
    case (funct3[1:0])
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = addr[0];
      default: misaligned_s = (addr[1:0] != 2'b00);
    endcase
  end
`else
  assign misaligned_s = 1'b0;
`endif

  // Next-state logic, request acceptance and pre-reset stall.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          stall_s = 1'b1;
          if (misaligned_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ACCESS;
            accept_s     = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        stall_s = 1'b1;
        if (mem_ready) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latch the accepted request; these drive mem_* and stay stable in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_wstrb_r <= 4'b0000;
      funct3_r    <= 3'b000;
      lane_r      <= 2'b00;
      is_load_r   <= 1'b0;
    end else if (accept_s) begin
      // Read wins when both requests are raised together.
      mem_we_r    <= ~mem_read;
      mem_addr_r  <= {addr[ADDR_W-1:2], 2'b00};
      mem_wdata_r <= mem_read ? {DATA_W{1'b0}} : store_wdata(funct3, store_data);
      mem_wstrb_r <= mem_read ? 4'b0000 : store_strb(funct3, addr[1:0]);
      funct3_r    <= funct3;
      lane_r      <= addr[1:0];
      is_load_r   <= mem_read;
    end
  end

  // Memory request is high exactly while in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_r <= 1'b0;
    end else begin
      mem_req_r <= (state_next_s == ST_ACCESS);
    end
  end

  // Completion pulse and misalign flag, both valid only in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      done_r     <= (state_next_s == ST_DONE);
      misalign_r <= (state_r == ST_IDLE) && req_s && misaligned_s;
    end
  end

  // Load result capture on the accepting edge; stores leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && mem_ready && is_load_r) begin
      data_out_r <= format_load(funct3_r, lane_r, mem_rdata);
    end
  end

  assign stall     = stall_s & ~rst;
  assign done      = done_r;
  assign misalign  = misalign_r;
  assign data_out  = data_out_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// Testbench for load_store_unit: a table of directed accesses with constant
// expectations, hand-written multi-cycle sequences, and randomized accesses
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam bit TRAP_EN =
`ifdef LSU_MISALIGN_TRAP_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic        misalign;
  logic [31:0] data_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .misalign   (misalign),
    .data_out   (data_out),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] model_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic int lane_off(input logic [31:0] a, input int nb);
    int o;
    o = int'(a % 32'd4);
    return (o / nb) * nb;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int nb;
    int off;
    longint v;
    nb  = size_bytes(f3);
    off = lane_off(a, nb);
    v   = (longint'(rd) >> (8 * off)) & ((64'sd1 <<< (8 * nb)) - 64'sd1);
    if (!f3[2] && nb < 4 && v >= (64'sd1 <<< (8 * nb - 1)))
      v = v - (64'sd1 <<< (8 * nb));
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    nb = size_bytes(f3);
    return 4'(((1 << nb) - 1) << lane_off(a, nb));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int nb;
    nb = size_bytes(f3);
    if (nb == 1) return (sd & 32'h0000_00FF) * 32'h0101_0101;
    else if (nb == 2) return (sd & 32'h0000_FFFF) * 32'h0001_0001;
    else return sd;
  endfunction

  // ---------------- one complete access with all its checks ----------------
  task automatic run_access(input bit ld, input bit both, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int waits, input bit trap,
                            input logic [31:0] e_addr, input logic [3:0] e_strb,
                            input logic [31:0] e_wdata, input logic [31:0] e_dout);
    bit load;
    load = ld | both;
    @(negedge clk);
    mem_read   = ld | both;
    mem_write  = ~ld | both;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    #1 chk("stall_cycle0", {31'd0, stall}, 32'd1);
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr       = $urandom;
    store_data = $urandom;
    funct3     = 3'($urandom);
    if (trap) begin
      chk("trap_done",     {31'd0, done},     32'd1);
      chk("trap_misalign", {31'd0, misalign}, 32'd1);
      chk("trap_no_req",   {31'd0, mem_req},  32'd0);
      chk("trap_dout",     data_out,          e_dout);
      @(negedge clk);
      chk("trap_done_off", {31'd0, done},     32'd0);
      chk("trap_mis_off",  {31'd0, misalign}, 32'd0);
      model_dout = e_dout;
      return;
    end
    chk("req_cycle1", {31'd0, mem_req}, 32'd1);
    chk("mem_we",     {31'd0, mem_we},  {31'd0, ~load});
    chk("mem_addr",   mem_addr,         e_addr);
    chk("stall_acc",  {31'd0, stall},   32'd1);
    if (!load) begin
      chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_strb});
      chk("mem_wdata", mem_wdata,          e_wdata);
    end
    for (int w = 0; w < waits; w++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      @(negedge clk);
      chk("wait_req",   {31'd0, mem_req}, 32'd1);
      chk("wait_addr",  mem_addr,         e_addr);
      chk("wait_stall", {31'd0, stall},   32'd1);
      chk("wait_done",  {31'd0, done},    32'd0);
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    chk("done_pulse",  {31'd0, done},     32'd1);
    chk("done_mis",    {31'd0, misalign}, 32'd0);
    chk("done_stall",  {31'd0, stall},    32'd0);
    chk("done_no_req", {31'd0, mem_req},  32'd0);
    chk("data_out",    data_out,          e_dout);
    @(negedge clk);
    chk("done_once",   {31'd0, done},     32'd0);
    model_dout = e_dout;
  endtask

  typedef struct {
    bit          ld;
    bit          both;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          waits;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 1, 32'h100, 4'b0000, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b0, 1'b0, 3'b001, 32'h00A, 32'h1234ABCD, 32'h0,        0, 32'h008, 4'b1100, 32'hABCDABCD, 32'h00000080};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h002, 32'h0,        32'h80017FFF, 0, 32'h000, 4'b0000, 32'h0,        32'hFFFF8001};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h000, 32'h0,        32'h1234F00D, 2, 32'h000, 4'b0000, 32'h0,        32'h0000F00D};
    vecs[6]  = '{1'b0, 1'b0, 3'b000, 32'h005, 32'h0000005A, 32'h0,        0, 32'h004, 4'b0010, 32'h5A5A5A5A, 32'h0000F00D};
    vecs[7]  = '{1'b0, 1'b0, 3'b010, 32'h010, 32'hCAFEBABE, 32'h0,        1, 32'h010, 4'b1111, 32'hCAFEBABE, 32'h0000F00D};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h020, 32'h0,        32'h01234567, 5, 32'h020, 4'b0000, 32'h0,        32'h01234567};
    vecs[9]  = '{1'b0, 1'b0, 3'b111, 32'h030, 32'h11223344, 32'h0,        0, 32'h030, 4'b1111, 32'h11223344, 32'h01234567};
    vecs[10] = '{1'b1, 1'b0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 0, 32'h000, 4'b0000, 32'h0,        32'h0000007F};
    vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h040, 32'hFFFFFFFF, 32'hA5A50F0F, 0, 32'h040, 4'b0000, 32'h0,        32'hA5A50F0F};
    vecs[12] = '{1'b0, 1'b0, 3'b100, 32'h007, 32'h123456C3, 32'h0,        0, 32'h004, 4'b1000, 32'hC3C3C3C3, 32'hA5A50F0F};
    vecs[13] = '{1'b0, 1'b0, 3'b101, 32'h006, 32'hFFFF1357, 32'h0,        3, 32'h004, 4'b1100, 32'h13571357, 32'hA5A50F0F};

    rst        = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    funct3     = 3'b010;
    addr       = 32'h0;
    store_data = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    model_dout = 32'h0;

    // Reset state: all outputs zero, stall low even with a request raised.
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall",    {31'd0, stall},    32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_dout",     data_out,          32'd0);
    chk("rst_req",      {31'd0, mem_req},  32'd0);
    chk("rst_we",       {31'd0, mem_we},   32'd0);
    chk("rst_addr",     mem_addr,          32'd0);
    chk("rst_wdata",    mem_wdata,         32'd0);
    chk("rst_wstrb",    {28'd0, mem_wstrb}, 32'd0);
    rst      = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd0);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      run_access(vecs[i].ld, vecs[i].both, vecs[i].f3, vecs[i].a, vecs[i].sd,
                 vecs[i].rd, vecs[i].waits, 1'b0, vecs[i].e_addr, vecs[i].e_strb,
                 vecs[i].e_wdata, vecs[i].e_dout);
    end

    // mem_ready outside ACCESS is ignored.
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("idle_ready_done", {31'd0, done},    32'd0);
    chk("idle_ready_req",  {31'd0, mem_req}, 32'd0);
    chk("idle_ready_dout", data_out,         model_dout);

    // Misaligned word load at 0x102.
    run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h55AA33CC, 0, TRAP_EN,
               32'h100, 4'b0000, 32'h0, TRAP_EN ? model_dout : 32'h55AA33CC);

    // Reset asserted in ACCESS: request dropped, data_out cleared, not captured.
    @(negedge clk);
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h200;
    @(negedge clk);
    mem_read = 1'b0;
    chk("racc_req", {31'd0, mem_req}, 32'd1);
    rst       = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF0000;
    #1 chk("racc_stall_in_rst", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b0;
    chk("racc_req_off", {31'd0, mem_req}, 32'd0);
    chk("racc_dout",    data_out,         32'd0);
    chk("racc_done",    {31'd0, done},    32'd0);
    chk("racc_idle",    {31'd0, stall},   32'd0);
    model_dout = 32'h0;
    @(negedge clk);
    chk("racc_still_idle", {31'd0, mem_req}, 32'd0);
    run_access(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h600DF00D, 1, 1'b0,
               32'h204, 4'b0000, 32'h0, 32'h600DF00D);

    // Back-to-back: request held through DONE is accepted only afterwards.
    @(negedge clk);
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h300;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h13579BDF;
    @(negedge clk);
    mem_ready = 1'b0;
    addr      = 32'h304;
    chk("b2b_done",  {31'd0, done},  32'd1);
    chk("b2b_stall", {31'd0, stall}, 32'd0);
    chk("b2b_dout",  data_out,       32'h13579BDF);
    @(negedge clk);
    chk("b2b_idle_stall", {31'd0, stall},   32'd1);
    chk("b2b_idle_req",   {31'd0, mem_req}, 32'd0);
    chk("b2b_idle_done",  {31'd0, done},    32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    chk("b2b_req2",  {31'd0, mem_req}, 32'd1);
    chk("b2b_addr2", mem_addr,         32'h304);
    mem_ready = 1'b1;
    mem_rdata = 32'h2468ACE0;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_dout2", data_out,      32'h2468ACE0);
    model_dout = 32'h2468ACE0;

    // Randomized accesses against the reference model.
    for (int r = 0; r < 60; r++) begin
      bit          ld;
      bit          both;
      bit          load;
      bit          trap;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] rd;
      int          nb;
      ld   = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 9) == 0);
      load = ld | both;
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      sd   = $urandom;
      rd   = $urandom;
      nb   = size_bytes(f3);
      trap = TRAP_EN && ((a % 32'(nb)) != 32'd0);
      run_access(ld, both, f3, a, sd, rd, $urandom_range(0, 3), trap,
                 a & 32'hFFFF_FFFC, model_strb(f3, a), model_wdata(f3, sd),
                 (load && !trap) ? model_load(f3, a, rd) : model_dout);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
